ram_dump_ctrl: RTL

//  Sequences readback of one channel's capture RAM to the host after a capture.

---
 rtl/ram_dump_if.sv | 34 +++
 rtl/ram_dump_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ram_dump_if.sv
// Command, RAM-read and UART-response signals of the capture RAM dump sequencer.
// The slave side is the sequencer. The master side is the surrounding logic: command interpreter, channel RAMs and UART.
interface ram_dump_if #(
  parameter int LOG2 = 9
);
  logic            start;
  logic [2:0]      ch_sel;
  logic            abort;
  logic [LOG2-1:0] addr_ptr;
  logic [7:0]      rdataCH1;
  logic [7:0]      rdataCH2;
  logic [7:0]      rdataCH3;
  logic [7:0]      rdataCH4;
  logic [7:0]      rdataCH5;
  logic            resp_sent;
  logic [LOG2-1:0] raddr;
  logic [7:0]      resp;
  logic            send_resp;
  logic            busy;
  logic            dump_done;
  logic            sel_err;

  modport master (
    output start, ch_sel, abort, addr_ptr,
    output rdataCH1, rdataCH2, rdataCH3, rdataCH4, rdataCH5, resp_sent,
    input  raddr, resp, send_resp, busy, dump_done, sel_err
  );

  modport slave (
    input  start, ch_sel, abort, addr_ptr,
    input  rdataCH1, rdataCH2, rdataCH3, rdataCH4, rdataCH5, resp_sent,
    output raddr, resp, send_resp, busy, dump_done, sel_err
  );
endinterface

// File: rtl/ram_dump_ctrl.sv
// Reads one channel's capture RAM back to the host, one byte per UART handshake.
// The walk starts at the oldest sample and wraps modulo ENTRIES.
module ram_dump_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic      clk,
  input  logic      rst,
  ram_dump_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, LATCH, WAIT} state_t;

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  state_t          state_q, state_d;
  logic [LOG2-1:0] raddr_q, raddr_d;
  logic [LOG2-1:0] cnt_q, cnt_d;
  logic [2:0]      ch_q, ch_d;
  logic [7:0]      resp_q, resp_d;
  logic            send_q, send_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [7:0]      rdata_sel;
  logic            sel_ok;
  logic            last_byte;

  assign sel_ok    = (bus.ch_sel >= 3'd1) && (bus.ch_sel <= 3'd5);
  assign last_byte = (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start && sel_ok) state_d = RD;
      RD:      state_d = bus.abort ? IDLE : LATCH;
      LATCH:   state_d = bus.abort ? IDLE : WAIT;
      WAIT: begin
        if (bus.abort)          state_d = IDLE;
        else if (bus.resp_sent) state_d = last_byte ? IDLE : RD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (ch_q)
      3'd1:    rdata_sel = bus.rdataCH1;
      3'd2:    rdata_sel = bus.rdataCH2;
      3'd3:    rdata_sel = bus.rdataCH3;
      3'd4:    rdata_sel = bus.rdataCH4;
      3'd5:    rdata_sel = bus.rdataCH5;
      default: rdata_sel = 8'h00;
    endcase
  end

  // Abort suppresses every update, so raddr and resp keep their last values.
  always_comb begin
    raddr_d = raddr_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    resp_d  = resp_q;
    send_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (sel_ok) begin
            raddr_d = (bus.addr_ptr > LAST) ? '0 : bus.addr_ptr;
            ch_d    = bus.ch_sel;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LATCH: begin
        if (!bus.abort) begin
          resp_d = rdata_sel;
          send_d = 1'b1;
        end
      end
      WAIT: begin
        if (!bus.abort && bus.resp_sent) begin
          if (last_byte) begin
            done_d = 1'b1;
          end else begin
            cnt_d   = cnt_q + LOG2'(1);
            raddr_d = (raddr_q == LAST) ? '0 : raddr_q + LOG2'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr_q <= '0;
      cnt_q   <= '0;
      ch_q    <= '0;
      resp_q  <= '0;
      send_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      raddr_q <= raddr_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      resp_q  <= resp_d;
      send_q  <= send_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.raddr     = raddr_q;
  assign bus.resp      = resp_q;
  assign bus.send_resp = send_q;
  assign bus.dump_done = done_q;
  assign bus.sel_err   = err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
